reorder_buffer: RTL and testbench
=================================

Name: reorder_buffer

Overview:
- Circular reorder buffer for the Tomasulo datapath.
- Allocates entries on issue and returns the next free tag and a full flag to issue control.
- Captures results from the CDB, serves operand lookups for two source tags, and retires in program order to the regfile, store path and fetch unit.
- Performs flush recovery on a mispredicted branch.

Parameters:
- data_width, 16, width of entry value and CDB data
- tag_width, 3, ROB tag width; depth = 2**tag_width (8)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- rob_write_enable  in  1  allocate entry at tail this cycle
- rob_opcode  in  4  lc3b_opcode of issued instruction
- rob_dest  in  3  architectural destination register
- rob_value_in  in  data_width  issue-time value (LEA result, branch recovery PC)
- rob_addr  out  tag_width  tag of current tail (next entry to allocate)
- rob_full  out  1  all entries occupied
- rob_sr1_read_addr  in  tag_width  lookup tag, port 1
- rob_sr2_read_addr  in  tag_width  lookup tag, port 2
- rob_sr1_value_out  out  data_width  value of entry at port-1 tag
- rob_sr2_value_out  out  data_width  value of entry at port-2 tag
- rob_sr1_valid_out  out  1  port-1 entry allocated and ready
- rob_sr2_valid_out  out  1  port-2 entry allocated and ready
- cdb_valid  in  1  CDB broadcast valid (CDB.valid)
- cdb_tag  in  tag_width  CDB producing tag (CDB.tag)
- cdb_data  in  data_width  CDB result (CDB.data)
- commit_ld_reg  out  1  write commit_value to regfile this cycle
- commit_dest  out  3  regfile destination
- commit_value  out  data_width  retired value
- commit_rob_entry  out  tag_width  retiring tag; regfile clears busy only if its rob_entry matches
- commit_store  out  1  head STR retired; store buffer may write memory
- flush  out  1  mispredict recovery pulse
- flush_pc  out  data_width  PC to refetch on flush

Behaviour:
- Per-entry state: valid, ready, opcode, dest, value. Pointers head and tail are tag_width wide and wrap modulo depth. count is 0..depth.
- Reset: all entry valid and ready bits = 0, head = tail = count = 0, all outputs = 0.
- rob_addr = tail. rob_full = (count == depth). Both are combinational from registered state.
- Issue: on rob_write_enable && !rob_full, the tail entry takes opcode, dest and rob_value_in, with valid = 1. ready = 1 at issue only for op_lea; otherwise 0. tail increments. A write while full is ignored.
- CDB capture: on cdb_valid, if the entry at cdb_tag is valid and not ready, set ready = 1.
  - Non-branch entries: value = cdb_data.
  - op_br entries: value is kept (recovery PC); a mispredict bit = cdb_data[0] is stored.
- Lookup ports are combinational: value = entry.value; valid = entry.valid && entry.ready. Lookups do not bypass the CDB; issue control checks the CDB itself.
- Commit happens at most one entry per cycle, when the head entry is valid && ready (registered state only; a CDB write to head is seen next cycle). It is a single registered stage: commit outputs are 1-cycle pulses asserted the cycle after the retire decision. On commit, head entry valid = 0, head increments, count decrements.
  - op_add/and/not/shf/ldr/lea: commit_ld_reg = 1 with dest, value and rob tag.
  - op_str: commit_store = 1, commit_ld_reg = 0.
  - op_br, no mispredict: retires silently.
  - op_br, mispredict: flush = 1 and flush_pc = entry value. All entries are invalidated, head = tail = count = 0.
- Simultaneous issue and commit: count is unchanged. When full, issue stays blocked that cycle, because rob_full is computed from the pre-commit count.
- Flush vs issue in the same cycle: flush wins and the issue is dropped.
- Flush vs CDB in the same cycle: the CDB update is discarded.
- Reset asserted mid-operation: immediate clear; no commit pulse is produced.

Optional Feature:
- ROB_PERF_CNT_EN
  - Defined: adds outputs perf_commits[31:0] and perf_flushes[31:0]. They are free-running, wrap at 2**32, clear on reset, and increment on each commit pulse and each flush pulse respectively.
  - Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset, then issue 8 ADDs dest R1..R0 -> rob_addr steps 0..7 then wraps to 0; rob_full = 1 after the 8th; a 9th write is ignored and tail stays 0.
- Issue ADD (tag 0), CDB valid tag 0 data 0x1234 -> next cycle rob_sr1_valid_out = 1, value 0x1234 at read addr 0; following cycle commit_ld_reg = 1, commit_value 0x1234, commit_rob_entry 0.
- Issue LEA value 0x3000 then ADD unresolved -> LEA commits without a CDB; ADD blocks head; no further commits until CDB tag 1.
- Issue STR, CDB tag for it -> commit_store = 1 pulse, commit_ld_reg = 0.
- Issue BR value 0x4010 plus 3 younger ADDs; CDB branch tag data 0x0001 -> flush = 1, flush_pc = 0x4010, rob_addr = 0, rob_full = 0, younger ADDs never commit.
- When full, issue and commit in the same cycle -> the write is dropped and count goes to 7; the next cycle's write is accepted.

Source files
------------

// File: rtl/reorder_buffer.sv
// Circular reorder buffer for the Tomasulo datapath.
// Allocates tags at issue, captures CDB results, serves two operand lookups
// and retires one entry per cycle in program order to the regfile, the store
// path and fetch (mispredict flush).
// Optional feature macro: ROB_PERF_CNT_EN adds perf_commits / perf_flushes.
module reorder_buffer #(
  parameter int data_width = 16,
  parameter int tag_width  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rob_write_enable,
  input  logic [3:0]            rob_opcode,
  input  logic [2:0]            rob_dest,
  input  logic [data_width-1:0] rob_value_in,
  output logic [tag_width-1:0]  rob_addr,
  output logic                  rob_full,
  input  logic [tag_width-1:0]  rob_sr1_read_addr,
  input  logic [tag_width-1:0]  rob_sr2_read_addr,
  output logic [data_width-1:0] rob_sr1_value_out,
  output logic [data_width-1:0] rob_sr2_value_out,
  output logic                  rob_sr1_valid_out,
  output logic                  rob_sr2_valid_out,
  input  logic                  cdb_valid,
  input  logic [tag_width-1:0]  cdb_tag,
  input  logic [data_width-1:0] cdb_data,
  output logic                  commit_ld_reg,
  output logic [2:0]            commit_dest,
  output logic [data_width-1:0] commit_value,
  output logic [tag_width-1:0]  commit_rob_entry,
  output logic                  commit_store,
  output logic                  flush,
  output logic [data_width-1:0] flush_pc
`ifdef ROB_PERF_CNT_EN
  ,
  output logic [31:0]           perf_commits,
  output logic [31:0]           perf_flushes
`endif
);

  localparam int DEPTH = 1 << tag_width;
  localparam logic [tag_width:0]   FULL_COUNT = (tag_width + 1)'(DEPTH);
  localparam logic [tag_width-1:0] TAG_ONE    = {{(tag_width - 1){1'b0}}, 1'b1};
  localparam logic [tag_width:0]   COUNT_ONE  = {{tag_width{1'b0}}, 1'b1};

  // lc3b opcodes the buffer needs to distinguish
  localparam logic [3:0] op_br  = 4'b0000;
  localparam logic [3:0] op_add = 4'b0001;
  localparam logic [3:0] op_and = 4'b0101;
  localparam logic [3:0] op_ldr = 4'b0110;
  localparam logic [3:0] op_str = 4'b0111;
  localparam logic [3:0] op_not = 4'b1001;
  localparam logic [3:0] op_shf = 4'b1101;
  localparam logic [3:0] op_lea = 4'b1110;

  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [DEPTH-1:0]      ready_q, ready_d;
  logic [DEPTH-1:0]      mispred_q, mispred_d;
  logic [3:0]            opcode_q [DEPTH];
  logic [3:0]            opcode_d [DEPTH];
  logic [2:0]            dest_q   [DEPTH];
  logic [2:0]            dest_d   [DEPTH];
  logic [data_width-1:0] value_q  [DEPTH];
  logic [data_width-1:0] value_d  [DEPTH];

  logic [tag_width-1:0]  head_q, head_d;
  logic [tag_width-1:0]  tail_q, tail_d;
  logic [tag_width:0]    count_q, count_d;

  logic                  commit_ld_reg_q, commit_ld_reg_d;
  logic [2:0]            commit_dest_q, commit_dest_d;
  logic [data_width-1:0] commit_value_q, commit_value_d;
  logic [tag_width-1:0]  commit_rob_entry_q, commit_rob_entry_d;
  logic                  commit_store_q, commit_store_d;
  logic                  flush_q, flush_d;
  logic [data_width-1:0] flush_pc_q, flush_pc_d;

  logic                  retire;
  logic                  retire_flush;
  logic                  issue;
  logic                  cdb_hit;
  logic                  head_writes_reg;

  // Allocation status and operand lookups come straight from registered state
  always_comb begin
    rob_addr          = tail_q;
    rob_full          = (count_q == FULL_COUNT);
    rob_sr1_value_out = value_q[rob_sr1_read_addr];
    rob_sr2_value_out = value_q[rob_sr2_read_addr];
    rob_sr1_valid_out = valid_q[rob_sr1_read_addr] & ready_q[rob_sr1_read_addr];
    rob_sr2_valid_out = valid_q[rob_sr2_read_addr] & ready_q[rob_sr2_read_addr];
  end

  // Retire / issue / capture decisions; a mispredicting head blocks issue
  always_comb begin
    retire       = valid_q[head_q] & ready_q[head_q];
    retire_flush = retire & (opcode_q[head_q] == op_br) & mispred_q[head_q];
    issue        = rob_write_enable & ~rob_full & ~retire_flush;
    cdb_hit      = cdb_valid & valid_q[cdb_tag] & ~ready_q[cdb_tag];
    case (opcode_q[head_q])
      op_add, op_and, op_not, op_shf, op_ldr, op_lea: head_writes_reg = 1'b1;
      default:                                        head_writes_reg = 1'b0;
    endcase
  end

  // Next entry and pointer state; flush overrides everything else
  always_comb begin
    valid_d   = valid_q;
    ready_d   = ready_q;
    mispred_d = mispred_q;
    opcode_d  = opcode_q;
    dest_d    = dest_q;
    value_d   = value_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;

    if (cdb_hit) begin
      ready_d[cdb_tag] = 1'b1;
      if (opcode_q[cdb_tag] == op_br) begin
        mispred_d[cdb_tag] = cdb_data[0];
      end else begin
        value_d[cdb_tag] = cdb_data;
      end
    end

    if (issue) begin
      valid_d[tail_q]   = 1'b1;
      ready_d[tail_q]   = (rob_opcode == op_lea);
      mispred_d[tail_q] = 1'b0;
      opcode_d[tail_q]  = rob_opcode;
      dest_d[tail_q]    = rob_dest;
      value_d[tail_q]   = rob_value_in;
      tail_d            = tail_q + TAG_ONE;
    end

    if (retire) begin
      valid_d[head_q] = 1'b0;
      ready_d[head_q] = 1'b0;
      head_d          = head_q + TAG_ONE;
    end

    case ({issue, retire})
      2'b10:   count_d = count_q + COUNT_ONE;
      2'b01:   count_d = count_q - COUNT_ONE;
      default: count_d = count_q;
    endcase

    if (retire_flush) begin
      valid_d   = '0;
      ready_d   = '0;
      mispred_d = '0;
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
    end
  end

  // Commit outputs for the registered retire stage; all zero when idle
  always_comb begin
    commit_ld_reg_d    = retire & head_writes_reg;
    commit_store_d     = retire & (opcode_q[head_q] == op_str);
    commit_dest_d      = retire ? dest_q[head_q] : 3'd0;
    commit_value_d     = retire ? value_q[head_q] : '0;
    commit_rob_entry_d = retire ? head_q : '0;
    flush_d            = retire_flush;
    flush_pc_d         = retire_flush ? value_q[head_q] : '0;
  end

  // Entry, pointer and commit-stage registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q            <= '0;
      ready_q            <= '0;
      mispred_q          <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        opcode_q[i] <= '0;
        dest_q[i]   <= '0;
        value_q[i]  <= '0;
      end
      head_q             <= '0;
      tail_q             <= '0;
      count_q            <= '0;
      commit_ld_reg_q    <= 1'b0;
      commit_dest_q      <= '0;
      commit_value_q     <= '0;
      commit_rob_entry_q <= '0;
      commit_store_q     <= 1'b0;
      flush_q            <= 1'b0;
      flush_pc_q         <= '0;
    end else begin
      valid_q            <= valid_d;
      ready_q            <= ready_d;
      mispred_q          <= mispred_d;
      opcode_q           <= opcode_d;
      dest_q             <= dest_d;
      value_q            <= value_d;
      head_q             <= head_d;
      tail_q             <= tail_d;
      count_q            <= count_d;
      commit_ld_reg_q    <= commit_ld_reg_d;
      commit_dest_q      <= commit_dest_d;
      commit_value_q     <= commit_value_d;
      commit_rob_entry_q <= commit_rob_entry_d;
      commit_store_q     <= commit_store_d;
      flush_q            <= flush_d;
      flush_pc_q         <= flush_pc_d;
    end
  end

  assign commit_ld_reg    = commit_ld_reg_q;
  assign commit_dest      = commit_dest_q;
  assign commit_value     = commit_value_q;
  assign commit_rob_entry = commit_rob_entry_q;
  assign commit_store     = commit_store_q;
  assign flush            = flush_q;
  assign flush_pc         = flush_pc_q;

`ifdef ROB_PERF_CNT_EN
  logic [31:0] perf_commits_q, perf_commits_d;
  logic [31:0] perf_flushes_q, perf_flushes_d;

  // Counters step together with the pulses they count
  always_comb begin
    perf_commits_d = perf_commits_q + {31'd0, commit_ld_reg_d | commit_store_d};
    perf_flushes_d = perf_flushes_q + {31'd0, flush_d};
  end

  // Free-running performance counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_commits_q <= '0;
      perf_flushes_q <= '0;
    end else begin
      perf_commits_q <= perf_commits_d;
      perf_flushes_q <= perf_flushes_d;
    end
  end

  assign perf_commits = perf_commits_q;
  assign perf_flushes = perf_flushes_q;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: fill/wrap, CDB capture, LEA, store,
// mispredict flush and full-with-commit behaviour.
module tb_reorder_buffer;

  localparam logic [3:0] opBr  = 4'b0000;
  localparam logic [3:0] opAdd = 4'b0001;
  localparam logic [3:0] opStr = 4'b0111;
  localparam logic [3:0] opLea = 4'b1110;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        robWriteEnable = 1'b0;
  logic [3:0]  robOpcode = '0;
  logic [2:0]  robDest = '0;
  logic [15:0] robValueIn = '0;
  logic [2:0]  robAddr;
  logic        robFull;
  logic [2:0]  sr1Addr = '0;
  logic [2:0]  sr2Addr = '0;
  logic [15:0] sr1Value;
  logic [15:0] sr2Value;
  logic        sr1Valid;
  logic        sr2Valid;
  logic        cdbValid = 1'b0;
  logic [2:0]  cdbTag = '0;
  logic [15:0] cdbData = '0;
  logic        commitLdReg;
  logic [2:0]  commitDest;
  logic [15:0] commitValue;
  logic [2:0]  commitRobEntry;
  logic        commitStore;
  logic        flushOut;
  logic [15:0] flushPc;
`ifdef ROB_PERF_CNT_EN
  logic [31:0] perfCommits;
  logic [31:0] perfFlushes;
`endif

  int checkCount = 0;
  int passCount = 0;
  int failCount = 0;

  reorder_buffer #(.data_width(16), .tag_width(3)) dut (
    .clk               (clk),
    .reset             (reset),
    .rob_write_enable  (robWriteEnable),
    .rob_opcode        (robOpcode),
    .rob_dest          (robDest),
    .rob_value_in      (robValueIn),
    .rob_addr          (robAddr),
    .rob_full          (robFull),
    .rob_sr1_read_addr (sr1Addr),
    .rob_sr2_read_addr (sr2Addr),
    .rob_sr1_value_out (sr1Value),
    .rob_sr2_value_out (sr2Value),
    .rob_sr1_valid_out (sr1Valid),
    .rob_sr2_valid_out (sr2Valid),
    .cdb_valid         (cdbValid),
    .cdb_tag           (cdbTag),
    .cdb_data          (cdbData),
    .commit_ld_reg     (commitLdReg),
    .commit_dest       (commitDest),
    .commit_value      (commitValue),
    .commit_rob_entry  (commitRobEntry),
    .commit_store      (commitStore),
    .flush             (flushOut),
    .flush_pc          (flushPc)
`ifdef ROB_PERF_CNT_EN
    ,
    .perf_commits      (perfCommits),
    .perf_flushes      (perfFlushes)
`endif
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of issue and CDB inputs, then advance past the edge
  task automatic applyStimulus(input logic we, input logic [3:0] op, input logic [2:0] dst,
                               input logic [15:0] val, input logic cv, input logic [2:0] ct,
                               input logic [15:0] cd);
    robWriteEnable = we;
    robOpcode      = op;
    robDest        = dst;
    robValueIn     = val;
    cdbValid       = cv;
    cdbTag         = ct;
    cdbData        = cd;
    tick();
  endtask

  task automatic idle();
    applyStimulus(1'b0, opAdd, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000);
  endtask

  // One immediate-assertion comparison
  task automatic checkOutput(input string name, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount = checkCount + 1;
    assert (observed === expected) passCount = passCount + 1;
    else begin
      failCount = failCount + 1;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", name, observed, expected);
    end
  endtask

  initial begin
    logic [2:0] d;

    // Reset state
    tick();
    tick();
    checkOutput("reset rob_addr", 32'(robAddr), 32'h0);
    checkOutput("reset rob_full", 32'(robFull), 32'h0);
    checkOutput("reset commit_ld_reg", 32'(commitLdReg), 32'h0);
    checkOutput("reset flush", 32'(flushOut), 32'h0);
    checkOutput("reset sr1_valid", 32'(sr1Valid), 32'h0);
    reset = 1'b0;

    // Fill all eight entries with unresolved ADDs
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("fill rob_addr %0d", i), 32'(robAddr), 32'(i));
      checkOutput($sformatf("fill rob_full %0d", i), 32'(robFull), 32'h0);
      d = 3'(i + 1);
      applyStimulus(1'b1, opAdd, d, 16'h0000, 1'b0, 3'd0, 16'h0000);
    end
    checkOutput("wrap rob_addr", 32'(robAddr), 32'h0);
    checkOutput("full after 8", 32'(robFull), 32'h1);
    applyStimulus(1'b1, opAdd, 3'd7, 16'h0000, 1'b0, 3'd0, 16'h0000);
    checkOutput("9th write tail", 32'(robAddr), 32'h0);
    checkOutput("9th write full", 32'(robFull), 32'h1);
    checkOutput("no commit while unresolved", 32'(commitLdReg), 32'h0);

    // Resolve the head, then issue while full in the retire cycle
    sr1Addr = 3'd0;
    applyStimulus(1'b0, opAdd, 3'd0, 16'h0000, 1'b1, 3'd0, 16'h0100);
    checkOutput("full cdb sr1_valid", 32'(sr1Valid), 32'h1);
    checkOutput("full cdb sr1_value", 32'(sr1Value), 32'h0100);
    checkOutput("full cdb no commit yet", 32'(commitLdReg), 32'h0);
    applyStimulus(1'b1, opAdd, 3'd2, 16'h0000, 1'b0, 3'd0, 16'h0000);
    checkOutput("full commit ld_reg", 32'(commitLdReg), 32'h1);
    checkOutput("full commit value", 32'(commitValue), 32'h0100);
    checkOutput("full commit entry", 32'(commitRobEntry), 32'h0);
    checkOutput("full commit dest", 32'(commitDest), 32'h1);
    checkOutput("full dropped write tail", 32'(robAddr), 32'h0);
    checkOutput("full dropped write not full", 32'(robFull), 32'h0);
    applyStimulus(1'b1, opAdd, 3'd3, 16'h0000, 1'b0, 3'd0, 16'h0000);
    checkOutput("next write accepted tail", 32'(robAddr), 32'h1);
    checkOutput("next write accepted full", 32'(robFull), 32'h1);
    checkOutput("commit pulse ends", 32'(commitLdReg), 32'h0);
    checkOutput("new entry not ready", 32'(sr1Valid), 32'h0);

    // Resolve tag 1 and reset before it can retire
    applyStimulus(1'b0, opAdd, 3'd0, 16'h0000, 1'b1, 3'd1, 16'h0222);
    reset = 1'b1;
    tick();
    checkOutput("midreset no commit", 32'(commitLdReg), 32'h0);
    checkOutput("midreset rob_addr", 32'(robAddr), 32'h0);
    checkOutput("midreset rob_full", 32'(robFull), 32'h0);
    checkOutput("midreset sr1_valid", 32'(sr1Valid), 32'h0);
    reset = 1'b0;

    // ADD tag 0 resolved by CDB, committed one cycle later
    applyStimulus(1'b1, opAdd, 3'd5, 16'h0000, 1'b0, 3'd0, 16'h0000);
    checkOutput("add issue rob_addr", 32'(robAddr), 32'h1);
    applyStimulus(1'b0, opAdd, 3'd0, 16'h0000, 1'b1, 3'd0, 16'h1234);
    checkOutput("add lookup valid", 32'(sr1Valid), 32'h1);
    checkOutput("add lookup value", 32'(sr1Value), 32'h1234);
    checkOutput("add not committed yet", 32'(commitLdReg), 32'h0);
    idle();
    checkOutput("add commit ld_reg", 32'(commitLdReg), 32'h1);
    checkOutput("add commit value", 32'(commitValue), 32'h1234);
    checkOutput("add commit entry", 32'(commitRobEntry), 32'h0);
    checkOutput("add commit dest", 32'(commitDest), 32'h5);

    // LEA commits without CDB; unresolved ADD behind it blocks the head
    sr2Addr = 3'd2;
    applyStimulus(1'b1, opLea, 3'd2, 16'h3000, 1'b0, 3'd0, 16'h0000);
    checkOutput("add pulse one cycle", 32'(commitLdReg), 32'h0);
    applyStimulus(1'b1, opAdd, 3'd3, 16'h0000, 1'b0, 3'd0, 16'h0000);
    checkOutput("lea commit ld_reg", 32'(commitLdReg), 32'h1);
    checkOutput("lea commit value", 32'(commitValue), 32'h3000);
    checkOutput("lea commit entry", 32'(commitRobEntry), 32'h1);
    checkOutput("lea commit dest", 32'(commitDest), 32'h2);
    checkOutput("pending add sr2_valid", 32'(sr2Valid), 32'h0);
    idle();
    checkOutput("blocked head 1", 32'(commitLdReg), 32'h0);
    idle();
    checkOutput("blocked head 2", 32'(commitLdReg), 32'h0);
    applyStimulus(1'b0, opAdd, 3'd0, 16'h0000, 1'b1, 3'd2, 16'h0055);
    checkOutput("blocked head 3", 32'(commitLdReg), 32'h0);
    checkOutput("resolved sr2_valid", 32'(sr2Valid), 32'h1);
    idle();
    checkOutput("unblocked commit", 32'(commitLdReg), 32'h1);
    checkOutput("unblocked value", 32'(commitValue), 32'h0055);
    checkOutput("unblocked entry", 32'(commitRobEntry), 32'h2);

    // STR retires through the store path
    applyStimulus(1'b1, opStr, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000);
    applyStimulus(1'b0, opAdd, 3'd0, 16'h0000, 1'b1, 3'd3, 16'hBEEF);
    checkOutput("str not yet", 32'(commitStore), 32'h0);
    idle();
    checkOutput("str commit_store", 32'(commitStore), 32'h1);
    checkOutput("str no ld_reg", 32'(commitLdReg), 32'h0);
    idle();
    checkOutput("str pulse ends", 32'(commitStore), 32'h0);

    // Mispredicted BR at tag 4 with three younger ADDs
    applyStimulus(1'b1, opBr, 3'd0, 16'h4010, 1'b0, 3'd0, 16'h0000);
    applyStimulus(1'b1, opAdd, 3'd1, 16'h0000, 1'b0, 3'd0, 16'h0000);
    applyStimulus(1'b1, opAdd, 3'd2, 16'h0000, 1'b0, 3'd0, 16'h0000);
    applyStimulus(1'b1, opAdd, 3'd3, 16'h0000, 1'b0, 3'd0, 16'h0000);
    applyStimulus(1'b0, opAdd, 3'd0, 16'h0000, 1'b1, 3'd4, 16'h0001);
    checkOutput("br resolved no flush yet", 32'(flushOut), 32'h0);
    applyStimulus(1'b1, opAdd, 3'd6, 16'h0000, 1'b1, 3'd5, 16'h7777);
    checkOutput("flush pulse", 32'(flushOut), 32'h1);
    checkOutput("flush_pc", 32'(flushPc), 32'h4010);
    checkOutput("flush rob_addr", 32'(robAddr), 32'h0);
    checkOutput("flush rob_full", 32'(robFull), 32'h0);
    checkOutput("flush no ld_reg", 32'(commitLdReg), 32'h0);
    sr1Addr = 3'd5;
    #1;
    checkOutput("flushed entry sr1_valid", 32'(sr1Valid), 32'h0);
    applyStimulus(1'b0, opAdd, 3'd0, 16'h0000, 1'b1, 3'd5, 16'h7777);
    checkOutput("flush pulse ends", 32'(flushOut), 32'h0);
    idle();
    checkOutput("younger add 1 dropped", 32'(commitLdReg), 32'h0);
    idle();
    checkOutput("younger add 2 dropped", 32'(commitLdReg), 32'h0);

    // Correctly predicted BR retires silently
    applyStimulus(1'b1, opBr, 3'd0, 16'h5000, 1'b0, 3'd0, 16'h0000);
    applyStimulus(1'b0, opAdd, 3'd0, 16'h0000, 1'b1, 3'd0, 16'h0000);
    idle();
    checkOutput("silent br no flush", 32'(flushOut), 32'h0);
    checkOutput("silent br no ld_reg", 32'(commitLdReg), 32'h0);
    checkOutput("silent br no store", 32'(commitStore), 32'h0);
    checkOutput("silent br rob_addr", 32'(robAddr), 32'h1);
    applyStimulus(1'b1, opAdd, 3'd4, 16'h0000, 1'b0, 3'd0, 16'h0000);
    applyStimulus(1'b0, opAdd, 3'd0, 16'h0000, 1'b1, 3'd1, 16'hAAAA);
    idle();
    checkOutput("after br commit", 32'(commitLdReg), 32'h1);
    checkOutput("after br value", 32'(commitValue), 32'hAAAA);
    checkOutput("after br entry", 32'(commitRobEntry), 32'h1);
    checkOutput("after br dest", 32'(commitDest), 32'h4);

`ifdef ROB_PERF_CNT_EN
    checkOutput("perf_commits", perfCommits, 32'd5);
    checkOutput("perf_flushes", perfFlushes, 32'd1);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
